// File: rtl/add_cla24.sv
// 24-bit two-level carry-lookahead adder with registered sum, group generate/propagate and carry-out.
// Six 4-bit lookahead blocks feed a second-level unit, so no carry ripples between blocks.
module add_cla24 (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [23:0] iA,
    input  logic [23:0] iB,
    input  logic        iC,
    output logic [23:0] oS,
    output logic        oG,
    output logic        oP,
    output logic        oC
);

    logic [23:0] bit_g;
    logic [23:0] bit_p;
    logic [23:0] carry;
    logic [5:0]  blk_g;
    logic [5:0]  blk_p;
    logic [5:0]  blk_cin;
    logic [23:0] sum;
    logic        grp_g;
    logic        grp_p;
    logic        grp_c;

    assign bit_g = iA & iB;
    assign bit_p = iA ^ iB;

    for (genvar k = 0; k < 6; k++) begin : g_blk
        logic [3:0] g;
        logic [3:0] p;
        logic       cin;

        assign g   = bit_g[4*k +: 4];
        assign p   = bit_p[4*k +: 4];
        assign cin = blk_cin[k];

        assign carry[4*k]     = cin;
        assign carry[4*k + 1] = g[0] | (p[0] & cin);
        assign carry[4*k + 2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        assign carry[4*k + 3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                              | (p[2] & p[1] & p[0] & cin);

        assign blk_g[k] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                        | (p[3] & p[2] & p[1] & g[0]);
        assign blk_p[k] = &p;
    end

    // Second-level lookahead: every block carry-in is a flat sum of products.
    assign blk_cin[0] = iC;
    assign blk_cin[1] = blk_g[0] | (blk_p[0] & iC);
    assign blk_cin[2] = blk_g[1] | (blk_p[1] & blk_g[0]) | (&blk_p[1:0] & iC);
    assign blk_cin[3] = blk_g[2] | (blk_p[2] & blk_g[1]) | (&blk_p[2:1] & blk_g[0])
                      | (&blk_p[2:0] & iC);
    assign blk_cin[4] = blk_g[3] | (blk_p[3] & blk_g[2]) | (&blk_p[3:2] & blk_g[1])
                      | (&blk_p[3:1] & blk_g[0]) | (&blk_p[3:0] & iC);
    assign blk_cin[5] = blk_g[4] | (blk_p[4] & blk_g[3]) | (&blk_p[4:3] & blk_g[2])
                      | (&blk_p[4:2] & blk_g[1]) | (&blk_p[4:1] & blk_g[0])
                      | (&blk_p[4:0] & iC);

    assign grp_g = blk_g[5] | (blk_p[5] & blk_g[4]) | (&blk_p[5:4] & blk_g[3])
                 | (&blk_p[5:3] & blk_g[2]) | (&blk_p[5:2] & blk_g[1])
                 | (&blk_p[5:1] & blk_g[0]);
    assign grp_p = &blk_p;
    assign grp_c = grp_g | (grp_p & iC);

    assign sum = bit_p ^ carry;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oS <= '0;
            oG <= 1'b0;
            oP <= 1'b0;
            oC <= 1'b0;
        end else begin
            oS <= sum;
            oG <= grp_g;
            oP <= grp_p;
            oC <= grp_c;
        end
    end

endmodule

// File: tb/tb_add_cla24.sv
// Scoreboard bench for add_cla24: driver queues expected results from an arithmetic
// reference model; an independent monitor checks each registered result one cycle later.
module tb_add_cla24;

    typedef struct packed {
        logic        c;
        logic        g;
        logic        p;
        logic [23:0] s;
    } res_t;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic [23:0] iA   = '0;
    logic [23:0] iB   = '0;
    logic        iC   = 1'b0;
    logic [23:0] oS;
    logic        oG;
    logic        oP;
    logic        oC;

    int   n_cmp = 0;
    int   n_bad = 0;
    res_t exp_q[$];

    add_cla24 dut (
        .iClk(iClk), .iRst(iRst), .iA(iA), .iB(iB), .iC(iC),
        .oS(oS), .oG(oG), .oP(oP), .oC(oC)
    );

    always #5 iClk = ~iClk;

    function automatic res_t model(input logic [23:0] a, input logic [23:0] b, input logic cin);
        res_t        r;
        logic [24:0] full;
        logic [24:0] no_cin;
        full   = {1'b0, a} + {1'b0, b} + {24'd0, cin};
        no_cin = {1'b0, a} + {1'b0, b};
        r.s = full[23:0];
        r.c = full[24];
        r.g = no_cin[24];            // generate: carry out regardless of carry-in
        r.p = ((a ^ b) == 24'hFFFFFF); // propagate: every bit position passes a carry
        return r;
    endfunction

    function automatic res_t outs();
        res_t r;
        r.c = oC; r.g = oG; r.p = oP; r.s = oS;
        return r;
    endfunction

    task automatic check(input string name, input res_t got, input res_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got S=%06h G=%b P=%b C=%b, want S=%06h G=%b P=%b C=%b",
                     name, got.s, got.g, got.p, got.c, want.s, want.g, want.p, want.c);
        end
    endtask

    task automatic drive(input logic [23:0] a, input logic [23:0] b, input logic cin);
        @(negedge iClk);
        iA = a; iB = b; iC = cin;
        exp_q.push_back(model(a, b, cin));
    endtask

    task automatic drive_exp(input logic [23:0] a, input logic [23:0] b, input logic cin,
                             input logic [23:0] s, input logic g, input logic p, input logic c);
        res_t r;
        r.s = s; r.g = g; r.p = p; r.c = c;
        @(negedge iClk);
        iA = a; iB = b; iC = cin;
        exp_q.push_back(r);
    endtask

    // Monitor: one result per rising edge out of reset.
    initial begin
        forever begin
            @(posedge iClk);
            #1;
            if (!iRst && exp_q.size() > 0) check("pipeline", outs(), exp_q.pop_front());
        end
    end

    initial begin
        logic [23:0] a;
        logic [23:0] b;
        int          budget;

        #1;
        check("reset_async", outs(), '0);
        repeat (2) @(posedge iClk);
        #1;
        check("reset_hold", outs(), '0);
        @(negedge iClk);
        iRst = 1'b0;

        drive_exp(24'd125, 24'd11, 1'b0, 24'd136, 1'b0, 1'b0, 1'b0);
        drive_exp(24'd127, 24'd105, 1'b1, 24'd233, 1'b0, 1'b0, 1'b0);
        drive_exp(24'h0000FF, 24'h0000FF, 1'b1, 24'h0001FF, 1'b0, 1'b0, 1'b0);
        drive_exp(24'hFFFFFF, 24'h000000, 1'b1, 24'h000000, 1'b0, 1'b1, 1'b1);
        drive_exp(24'hFFFFFF, 24'h000000, 1'b0, 24'hFFFFFF, 1'b0, 1'b1, 1'b0);
        drive_exp(24'hFFFFFF, 24'hFFFFFF, 1'b0, 24'hFFFFFE, 1'b1, 1'b0, 1'b1);
        drive(24'h800000, 24'h800000, 1'b1);
        drive(24'h0F0F0F, 24'hF0F0F0, 1'b1);

        // Mid-cycle reset with nonzero outputs; the inputs present now must never surface.
        @(posedge iClk);
        #3;
        iA = 24'h123456; iB = 24'h654321; iC = 1'b1;
        #1;
        iRst = 1'b1;
        #1;
        check("reset_mid_cycle", outs(), '0);
        @(posedge iClk);
        #1;
        check("reset_held_edge", outs(), '0);
        @(negedge iClk);
        iRst = 1'b0;
        iA = 24'h00ABCD; iB = 24'h000123; iC = 1'b0;
        exp_q.push_back(model(24'h00ABCD, 24'h000123, 1'b0));

        for (int i = 0; i < 10000; i++) begin
            a = 24'($urandom);
            case ($urandom_range(0, 3))
                0:       b = ~a;
                1:       b = (~a) ^ (24'd1 << $urandom_range(0, 23));
                default: b = 24'($urandom);
            endcase
            drive(a, b, 1'($urandom));
        end

        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(posedge iClk);
            #2;
            budget++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/add_cla24.md
ADD_CLA24 -- requirements
Module: add_cla24

Interface
REQ-001 SHALL have port: iClk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: iRst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: iA  input  24  addend A, unsigned.
REQ-004 SHALL have port: iB  input  24  addend B, unsigned.
REQ-005 SHALL have port: iC  input  1  carry-in.
REQ-006 SHALL have port: oS  output  24  registered sum bits [23:0].
REQ-007 SHALL have port: oG  output  1  registered 24-bit group generate.
REQ-008 SHALL have port: oP  output  1  registered 24-bit group propagate.
REQ-009 SHALL have port: oC  output  1  registered carry-out.
REQ-010 SHALL have no parameters; widths are fixed at 24.

Function
REQ-011 SHALL compute per-bit terms g[i] = iA[i] & iB[i], p[i] = iA[i] ^ iB[i], for i = 0..23.
REQ-012 SHALL organise carry logic as six 4-bit carry-lookahead blocks: each produces internal carries plus block generate Gk and block propagate Pk.
REQ-013 SHALL use a second-level lookahead unit over the six (Gk, Pk) pairs and iC to derive block carry-ins c4, c8, c12, c16, c20 with no ripple between blocks.
REQ-014 SHALL compute sum bit s[i] = p[i] ^ c[i], where c[0] = iC.
REQ-015 SHALL compute group propagate P = AND of p[23:0]; it is independent of iC.
REQ-016 SHALL compute group generate G as the standard lookahead of g/p over bits 23..0; it is independent of iC.
REQ-017 SHALL compute carry-out C = G | (P & iC); {C, s} SHALL equal iA + iB + iC exactly for all inputs.
REQ-018 SHALL register s, G, P and C into oS, oG, oP, oC on each rising iClk edge; latency is exactly 1 cycle and throughput is one addition per cycle.
REQ-019 SHALL have no enable or handshake; inputs are sampled on every rising edge.
REQ-020 SHALL handle wrap-around: a sum >= 2^24 SHALL produce oS = sum mod 2^24 and oC = 1.
REQ-021 SHALL keep the combinational path free of latches and any stateful element other than the output registers.

Reset
REQ-022 SHALL clear oS, oG, oP and oC to 0 immediately when iRst rises, independent of iClk.
REQ-023 SHALL hold all outputs at 0 while iRst is high.
REQ-024 SHALL load the result of the inputs present at the first rising edge after iRst deasserts.
REQ-025 Reset asserted mid-operation SHALL discard any pending result; no stale value reappears after release.

Verification
REQ-026 SHALL cover iA=125, iB=11, iC=0 -> one cycle later oS=136, oC=0, oP=0.
REQ-027 SHALL cover iA=127, iB=105, iC=1 -> one cycle later oS=233, oC=0, oP=0.
REQ-028 SHALL cover iA=0x0000FF, iB=0x0000FF, iC=1 -> one cycle later oS=511 (0x0001FF), oC=0, oP=0.
REQ-029 SHALL cover iA=0xFFFFFF, iB=0, iC=1 -> oS=0, oC=1, oP=1, oG=0; then the same inputs with iC=0 -> oS=0xFFFFFF, oC=0, oP=1.
REQ-030 SHALL cover iA=0xFFFFFF, iB=0xFFFFFF, iC=0 -> oS=0xFFFFFE, oC=1, oG=1, oP=0.
REQ-031 SHALL cover asserting iRst between clock edges with nonzero outputs -> all outputs 0 without a clock edge; after release, the next edge loads the current sum. A randomized sweep of at least 10^4 vectors SHALL also match {oC, oS} = iA + iB + iC.
